// File: rtl/watch_calendar.sv
// watch_calendar: calendar and time-of-day counter.
// Advances second/minute/hour/day/month/year on a one-cycle clk1sec strobe.
// Uses Gregorian leap years and full-width years, and tracks day-of-week.
// Loads through set_time are validated against the loaded year's calendar.
// day_tick, year_tick and set_err are one-cycle registered pulses for the
// alarm and display logic.
module watch_calendar #(
  parameter int YEAR_W    = 12,
  parameter int RST_YEAR  = 2021,
  parameter int RST_MONTH = 5,
  parameter int RST_DAY   = 30,
  parameter int RST_DOW   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk1sec,
  input  logic              set_time,
  input  logic [YEAR_W+39:0] set_value,
  input  logic [2:0]        set_dow,
  output logic [YEAR_W-1:0] year,
  output logic [7:0]        month,
  output logic [7:0]        day,
  output logic [7:0]        hour,
  output logic [7:0]        minute,
  output logic [7:0]        second,
  output logic [2:0]        dow,
  output logic              set_err,
  output logic              day_tick,
  output logic              year_tick
);

  // Gregorian leap rule; year 0 counts as leap (divisible by 400).
  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic [15:0] ye;
    ye = 16'(y);
    return ((ye[1:0] == 2'd0) && ((ye % 16'd100) != 16'd0)) ||
           ((ye % 16'd400) == 16'd0);
  endfunction

  // Days in month; an out-of-range month yields 0 so no day can validate.
  function automatic logic [7:0] month_len(input logic [7:0] m, input logic leap);
    logic [7:0] len;
    case (m)
      8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd10, 8'd12: len = 8'd31;
      8'd4, 8'd6, 8'd9, 8'd11:                    len = 8'd30;
      8'd2:    len = leap ? 8'd29 : 8'd28;
      default: len = 8'd0;
    endcase
    return len;
  endfunction

  logic [YEAR_W-1:0] year_r, year_s;
  logic [7:0]        month_r, month_s, day_r, day_s;
  logic [7:0]        hour_r, hour_s, minute_r, minute_s, second_r, second_s;
  logic [2:0]        dow_r, dow_s;
  logic              set_err_r, set_err_s, day_tick_r, day_tick_s;
  logic              year_tick_r, year_tick_s;

  logic [YEAR_W-1:0] ld_year_s;
  logic [7:0]        ld_month_s, ld_day_s, ld_hour_s, ld_minute_s, ld_second_s;
  logic              load_ok_s;
  logic [7:0]        cur_len_s;

  assign ld_year_s   = set_value[YEAR_W+39:40];
  assign ld_month_s  = set_value[39:32];
  assign ld_day_s    = set_value[31:24];
  assign ld_hour_s   = set_value[23:16];
  assign ld_minute_s = set_value[15:8];
  assign ld_second_s = set_value[7:0];

  // Load validation against the loaded year's leap status; dow is only range-checked.
  assign load_ok_s = (ld_month_s >= 8'd1) && (ld_month_s <= 8'd12) &&
                     (ld_day_s >= 8'd1) &&
                     (ld_day_s <= month_len(ld_month_s, is_leap(ld_year_s))) &&
                     (ld_hour_s <= 8'd23) && (ld_minute_s <= 8'd59) &&
                     (ld_second_s <= 8'd59) && (set_dow <= 3'd6);

  assign cur_len_s = month_len(month_r, is_leap(year_r));

  // Next-state: load beats tick (a tick coinciding with any load is dropped).
  always_comb begin
    year_s      = year_r;
    month_s     = month_r;
    day_s       = day_r;
    hour_s      = hour_r;
    minute_s    = minute_r;
    second_s    = second_r;
    dow_s       = dow_r;
    set_err_s   = 1'b0;
    day_tick_s  = 1'b0;
    year_tick_s = 1'b0;
    if (set_time) begin
      if (load_ok_s) begin
        year_s   = ld_year_s;
        month_s  = ld_month_s;
        day_s    = ld_day_s;
        hour_s   = ld_hour_s;
        minute_s = ld_minute_s;
        second_s = ld_second_s;
        dow_s    = set_dow;
      end else begin
        set_err_s = 1'b1;
      end
    end else if (clk1sec) begin
      if (second_r == 8'd59) begin
        second_s = 8'd0;
        if (minute_r == 8'd59) begin
          minute_s = 8'd0;
          if (hour_r == 8'd23) begin
            hour_s     = 8'd0;
            day_tick_s = 1'b1;
            dow_s      = (dow_r == 3'd6) ? 3'd0 : dow_r + 3'd1;
            if (day_r == cur_len_s) begin
              day_s = 8'd1;
              if (month_r == 8'd12) begin
                month_s     = 8'd1;
                year_s      = year_r + YEAR_W'(1);
                year_tick_s = 1'b1;
              end else begin
                month_s = month_r + 8'd1;
              end
            end else begin
              day_s = day_r + 8'd1;
            end
          end else begin
            hour_s = hour_r + 8'd1;
          end
        end else begin
          minute_s = minute_r + 8'd1;
        end
      end else begin
        second_s = second_r + 8'd1;
      end
    end else begin
      year_s = year_r;
    end
  end

  // State and pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      year_r      <= YEAR_W'(RST_YEAR);
      month_r     <= 8'(RST_MONTH);
      day_r       <= 8'(RST_DAY);
      hour_r      <= 8'd0;
      minute_r    <= 8'd0;
      second_r    <= 8'd0;
      dow_r       <= 3'(RST_DOW);
      set_err_r   <= 1'b0;
      day_tick_r  <= 1'b0;
      year_tick_r <= 1'b0;
    end else begin
      year_r      <= year_s;
      month_r     <= month_s;
      day_r       <= day_s;
      hour_r      <= hour_s;
      minute_r    <= minute_s;
      second_r    <= second_s;
      dow_r       <= dow_s;
      set_err_r   <= set_err_s;
      day_tick_r  <= day_tick_s;
      year_tick_r <= year_tick_s;
    end
  end

  assign year      = year_r;
  assign month     = month_r;
  assign day       = day_r;
  assign hour      = hour_r;
  assign minute    = minute_r;
  assign second    = second_r;
  assign dow       = dow_r;
  assign set_err   = set_err_r;
  assign day_tick  = day_tick_r;
  assign year_tick = year_tick_r;

endmodule

// File: tb/tb_watch_calendar.sv
// Directed testbench for watch_calendar (YEAR_W = 12, default reset date).
module tb_watch_calendar;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk1sec = 1'b0;
  logic        set_time = 1'b0;
  logic [51:0] set_value = 52'd0;
  logic [2:0]  set_dow = 3'd0;
  logic [11:0] year;
  logic [7:0]  month, day, hour, minute, second;
  logic [2:0]  dow;
  logic        set_err, day_tick, year_tick;

  int n_cmp = 0;
  int n_err = 0;
  int yt_count;
  int yt_idx;
  int dt_count;

  watch_calendar dut (
    .clk(clk), .rst(rst), .clk1sec(clk1sec), .set_time(set_time),
    .set_value(set_value), .set_dow(set_dow),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
    .second(second), .dow(dow), .set_err(set_err), .day_tick(day_tick),
    .year_tick(year_tick)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input logic [11:0] y, input logic [7:0] mo,
                            input logic [7:0] d, input logic [7:0] h, input logic [7:0] mi,
                            input logic [7:0] s, input logic [2:0] dw);
    check(tag, 64'({year, month, day, hour, minute, second, dow}),
               64'({y, mo, d, h, mi, s, dw}));
  endtask

  task automatic check_pulses(input string tag, input logic e, input logic dt, input logic yt);
    check(tag, 64'({set_err, day_tick, year_tick}), 64'({e, dt, yt}));
  endtask

  task automatic drive_load(input logic [11:0] y, input logic [7:0] mo, input logic [7:0] d,
                            input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                            input logic [2:0] dw, input logic with_tick);
    set_value = {y, mo, d, h, mi, s};
    set_dow   = dw;
    set_time  = 1'b1;
    clk1sec   = with_tick;
    step();
    set_time  = 1'b0;
    clk1sec   = 1'b0;
  endtask

  task automatic tick();
    clk1sec = 1'b1;
    step();
    clk1sec = 1'b0;
  endtask

  initial begin
    // Reset for two cycles
    rst = 1'b0;
    step();
    step();
    check_time("reset_time", 12'd2021, 8'd5, 8'd30, 8'd0, 8'd0, 8'd0, 3'd0);
    check_pulses("reset_pulses", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    check_time("hold_idle", 12'd2021, 8'd5, 8'd30, 8'd0, 8'd0, 8'd0, 3'd0);

    // Leap-year February 2024
    drive_load(12'd2024, 8'd2, 8'd28, 8'd23, 8'd59, 8'd59, 3'd3, 1'b0);
    check_time("load_2024", 12'd2024, 8'd2, 8'd28, 8'd23, 8'd59, 8'd59, 3'd3);
    check_pulses("load_no_pulse", 1'b0, 1'b0, 1'b0);
    tick();
    check_time("leap_feb29", 12'd2024, 8'd2, 8'd29, 8'd0, 8'd0, 8'd0, 3'd4);
    check_pulses("leap_day_tick", 1'b0, 1'b1, 1'b0);
    step();
    check_pulses("day_tick_one_cycle", 1'b0, 1'b0, 1'b0);

    // Century non-leap 2100
    drive_load(12'd2100, 8'd2, 8'd28, 8'd23, 8'd59, 8'd59, 3'd0, 1'b0);
    tick();
    check_time("nonleap_2100", 12'd2100, 8'd3, 8'd1, 8'd0, 8'd0, 8'd0, 3'd1);

    // 30-day month end
    drive_load(12'd2021, 8'd4, 8'd30, 8'd23, 8'd59, 8'd59, 3'd6, 1'b0);
    tick();
    check_time("april_end", 12'd2021, 8'd5, 8'd1, 8'd0, 8'd0, 8'd0, 3'd0);

    // Year wrap at 2^12-1
    drive_load(12'd4095, 8'd12, 8'd31, 8'd23, 8'd59, 8'd59, 3'd2, 1'b0);
    tick();
    check_time("year_wrap", 12'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 3'd3);
    check_pulses("wrap_pulses", 1'b0, 1'b1, 1'b1);

    // Invalid loads from 2021-05-30 00:00:05
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_time("five_ticks", 12'd2021, 8'd5, 8'd30, 8'd0, 8'd0, 8'd5, 3'd0);
    drive_load(12'd2023, 8'd2, 8'd29, 8'd10, 8'd0, 8'd0, 3'd3, 1'b0);
    check_time("bad_feb29_hold", 12'd2021, 8'd5, 8'd30, 8'd0, 8'd0, 8'd5, 3'd0);
    check_pulses("bad_feb29_err", 1'b1, 1'b0, 1'b0);
    step();
    check_pulses("set_err_one_cycle", 1'b0, 1'b0, 1'b0);
    drive_load(12'd2021, 8'd4, 8'd31, 8'd1, 8'd0, 8'd0, 3'd1, 1'b0);
    check_pulses("bad_apr31_err", 1'b1, 1'b0, 1'b0);
    drive_load(12'd2021, 8'd6, 8'd1, 8'd1, 8'd0, 8'd0, 3'd7, 1'b0);
    check_pulses("bad_dow7_err", 1'b1, 1'b0, 1'b0);
    drive_load(12'd2021, 8'd6, 8'd1, 8'd24, 8'd0, 8'd0, 3'd1, 1'b1);
    check_time("bad_hour_tick_dropped", 12'd2021, 8'd5, 8'd30, 8'd0, 8'd0, 8'd5, 3'd0);
    check_pulses("bad_hour_err", 1'b1, 1'b0, 1'b0);
    drive_load(12'd2000, 8'd2, 8'd29, 8'd10, 8'd0, 8'd0, 3'd2, 1'b0);
    check_time("good_2000_feb29", 12'd2000, 8'd2, 8'd29, 8'd10, 8'd0, 8'd0, 3'd2);
    check_pulses("good_2000_no_err", 1'b0, 1'b0, 1'b0);

    // Priority: load beats tick, reset beats both
    drive_load(12'd2022, 8'd1, 8'd1, 8'd12, 8'd0, 8'd0, 3'd6, 1'b1);
    check_time("load_over_tick", 12'd2022, 8'd1, 8'd1, 8'd12, 8'd0, 8'd0, 3'd6);
    rst = 1'b0;
    drive_load(12'd2030, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 3'd1, 1'b1);
    rst = 1'b1;
    check_time("reset_over_all", 12'd2021, 8'd5, 8'd30, 8'd0, 8'd0, 8'd0, 3'd0);
    check_pulses("reset_over_all_pulses", 1'b0, 1'b0, 1'b0);

    // 120 back-to-back ticks across new year
    drive_load(12'd2021, 8'd12, 8'd31, 8'd23, 8'd58, 8'd0, 3'd5, 1'b0);
    yt_count = 0;
    yt_idx   = -1;
    dt_count = 0;
    clk1sec  = 1'b1;
    for (int i = 0; i < 120; i++) begin
      step();
      if (year_tick) begin
        yt_count++;
        yt_idx = i;
      end
      if (day_tick) dt_count++;
    end
    clk1sec = 1'b0;
    check_time("b2b_new_year", 12'd2022, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 3'd6);
    check("b2b_year_tick_count", 64'(yt_count), 64'd1);
    check("b2b_year_tick_index", 64'(yt_idx), 64'd119);
    check("b2b_day_tick_count", 64'(dt_count), 64'd1);
    step();
    check_pulses("b2b_pulses_clear", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
